// File: rtl/osd_spi_ram_ctrl_if.sv
// SPI slave BRAM-side bus: strobes, byte address and data in both directions.
interface osd_spi_ram_ctrl_if #(
    parameter int unsigned c_addr_bits = 32
);
    logic                   spi_rd;
    logic                   spi_wr;
    logic [c_addr_bits-1:0] spi_addr;
    logic [7:0]             spi_wdata;
    logic [7:0]             spi_rdata;

    modport master (
        output spi_rd, spi_wr, spi_addr, spi_wdata,
        input  spi_rdata
    );

    modport slave (
        input  spi_rd, spi_wr, spi_addr, spi_wdata,
        output spi_rdata
    );
endinterface

// File: rtl/osd_spi_ram_ctrl.sv
// OSD character RAM plus vsync-shadowed control registers behind the SPI slave bus.
// Optional macro OSD_AUTOHIDE_EN: hides the OSD after c_autohide_frames idle frames.
module osd_spi_ram_ctrl #(
    parameter logic [7:0]  c_addr_osd        = 8'hFD,
    parameter logic [7:0]  c_addr_ctrl       = 8'hFE,
    parameter int unsigned c_ram_bits        = 11,
    parameter int unsigned c_addr_bits       = 32,
    parameter int unsigned c_autohide_frames = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    osd_spi_ram_ctrl_if.slave     bus,
    input  logic                  vsync,
    input  logic [c_ram_bits-1:0] disp_addr,
    output logic [7:0]            disp_data,
    output logic                  osd_en,
    output logic [7:0]            osd_x,
    output logic [7:0]            osd_y
);
    localparam int unsigned c_ram_depth = 1 << c_ram_bits;

    logic [7:0] ram [c_ram_depth];

    logic                  wr_q;
    logic                  vs_q;
    logic                  shadow_en;
    logic [7:0]            shadow_x;
    logic [7:0]            shadow_y;
    logic                  pending;
    logic [7:0]            frame_cnt;

    logic [7:0]            addr_hi;
    logic                  hit_ram;
    logic                  hit_ctrl;
    logic [c_ram_bits-1:0] ram_idx;
    logic [1:0]            reg_off;
    logic                  wr_ev;
    logic                  vs_ev;
    logic                  ctrl_wr;
    logic [7:0]            rdata_c;

    // Address bits between the RAM index and the region byte only alias.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.spi_rd, bus.spi_addr[c_addr_bits-9:c_ram_bits]};

    assign addr_hi  = bus.spi_addr[c_addr_bits-1 -: 8];
    assign hit_ram  = (addr_hi == c_addr_osd);
    assign hit_ctrl = (addr_hi == c_addr_ctrl);
    assign ram_idx  = bus.spi_addr[c_ram_bits-1:0];
    assign reg_off  = bus.spi_addr[1:0];
    assign wr_ev    = bus.spi_wr && !wr_q;
    assign vs_ev    = vsync && !vs_q;
    assign ctrl_wr  = wr_ev && hit_ctrl && (reg_off != 2'd3);

    // Readback mux for the currently presented address.
    always_comb begin
        rdata_c = 8'h00;
        if (hit_ram) begin
            rdata_c = ram[ram_idx];
        end else if (hit_ctrl) begin
            case (reg_off)
                2'd0:    rdata_c = {pending, 6'b0, shadow_en};
                2'd1:    rdata_c = shadow_x;
                2'd2:    rdata_c = shadow_y;
                default: rdata_c = frame_cnt;
            endcase
        end
    end

    // RAM contents survive reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ev && hit_ram) begin
            ram[ram_idx] <= bus.spi_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data     <= 8'h00;
            bus.spi_rdata <= 8'h00;
        end else begin
            disp_data     <= ram[disp_addr];
            bus.spi_rdata <= rdata_c;
        end
    end

`ifdef OSD_AUTOHIDE_EN
    localparam int unsigned c_idle_bits =
        ($clog2(c_autohide_frames + 1) > 8) ? $clog2(c_autohide_frames + 1) : 8;

    logic [c_idle_bits-1:0] idle_cnt;
    logic                   idle_hit;

    assign idle_hit = vs_ev && !wr_ev &&
                      (idle_cnt == c_idle_bits'(c_autohide_frames - 1));

    // Idle frame counter, saturating at the autohide threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (wr_ev) begin
            idle_cnt <= '0;
        end else if (vs_ev && (idle_cnt != c_idle_bits'(c_autohide_frames))) begin
            idle_cnt <= idle_cnt + c_idle_bits'(1);
        end
    end
`else
    localparam int unsigned unused_autohide = c_autohide_frames;

    logic idle_hit;
    assign idle_hit = 1'b0;
`endif

    // Shadow registers load on SPI writes; active set loads on vsync edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            vs_q      <= 1'b0;
            shadow_en <= 1'b0;
            shadow_x  <= 8'h00;
            shadow_y  <= 8'h00;
            pending   <= 1'b0;
            frame_cnt <= 8'h00;
            osd_en    <= 1'b0;
            osd_x     <= 8'h00;
            osd_y     <= 8'h00;
        end else begin
            wr_q <= bus.spi_wr;
            vs_q <= vsync;
            if (vs_ev) begin
                osd_en    <= shadow_en;
                osd_x     <= shadow_x;
                osd_y     <= shadow_y;
                pending   <= 1'b0;
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A coincident write lands in shadow and keeps pending set.
            if (ctrl_wr) begin
                pending <= 1'b1;
                case (reg_off)
                    2'd0:    shadow_en <= bus.spi_wdata[0];
                    2'd1:    shadow_x  <= bus.spi_wdata;
                    default: shadow_y  <= bus.spi_wdata;
                endcase
            end
            if (idle_hit) begin
                shadow_en <= 1'b0;
                osd_en    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_osd_spi_ram_ctrl.sv
// Directed scoreboard bench for osd_spi_ram_ctrl (default and OSD_AUTOHIDE_EN builds).
module tb_osd_spi_ram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic [10:0] disp_addr = '0;
    logic [7:0]  disp_data;
    logic        osd_en;
    logic [7:0]  osd_x;
    logic [7:0]  osd_y;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    osd_spi_ram_ctrl_if #(.c_addr_bits(32)) bus ();

    osd_spi_ram_ctrl #(
        .c_addr_osd       (8'hFD),
        .c_addr_ctrl      (8'hFE),
        .c_ram_bits       (11),
        .c_addr_bits      (32),
        .c_autohide_frames(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .vsync    (vsync),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .osd_en   (osd_en),
        .osd_x    (osd_x),
        .osd_y    (osd_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_write(input logic [31:0] addr, input logic [7:0] data);
        bus.spi_addr  = addr;
        bus.spi_wdata = data;
        bus.spi_wr    = 1'b1;
        tick();
        bus.spi_wr    = 1'b0;
        tick();
    endtask

    // Expected byte is queued as the address is driven, popped when spi_rdata lands.
    task automatic spi_read(input logic [31:0] addr, input logic [7:0] exp, input string tag);
        bus.spi_addr = addr;
        bus.spi_rd   = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        bus.spi_rd   = 1'b0;
        check(tag_q.pop_front(), bus.spi_rdata, exp_q.pop_front());
    endtask

    task automatic vs_edge();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic check_osd(input string tag, input logic en, input logic [7:0] x,
                             input logic [7:0] y);
        check({tag, "_en"}, {7'b0, osd_en}, {7'b0, en});
        check({tag, "_x"}, osd_x, x);
        check({tag, "_y"}, osd_y, y);
    endtask

    initial begin
        logic hide;
`ifdef OSD_AUTOHIDE_EN
        hide = 1'b1;
`else
        hide = 1'b0;
`endif
        bus.spi_rd    = 1'b0;
        bus.spi_wr    = 1'b0;
        bus.spi_addr  = '0;
        bus.spi_wdata = '0;
        tick();
        tick();
        check("rst_rdata", bus.spi_rdata, 8'h00);
        check("rst_disp", disp_data, 8'h00);
        check_osd("rst_osd", 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        tick();

        // Basic RAM write/readback and display port.
        spi_write(32'hFD00_0010, 8'hA5);
        spi_read(32'hFD00_0010, 8'hA5, "ram_rd_10");
        disp_addr = 11'h010;
        tick();
        check("disp_10", disp_data, 8'hA5);
        spi_read(32'hFD00_0810, 8'hA5, "ram_alias_810");
        spi_read(32'hFDFF_0010, 8'hA5, "ram_alias_hi");
        spi_write(32'h1200_0010, 8'hEE);
        spi_read(32'h1200_0010, 8'h00, "unmapped_rd");
        spi_read(32'hFD00_0010, 8'hA5, "unmapped_no_wr");

        // Long spi_wr with incrementing address writes only once.
        spi_write(32'hFD00_0021, 8'h77);
        bus.spi_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.spi_addr  = 32'hFD00_0020 + 32'(i);
            bus.spi_wdata = 8'h5A + 8'(i);
            tick();
        end
        bus.spi_wr = 1'b0;
        tick();
        spi_read(32'hFD00_0020, 8'h5A, "hold_wr_20");
        spi_read(32'hFD00_0021, 8'h77, "hold_wr_21");

        // Same-address SPI write and display read returns the old byte first.
        spi_write(32'hFD00_0030, 8'h11);
        disp_addr = 11'h030;
        tick();
        bus.spi_addr  = 32'hFD00_0030;
        bus.spi_wdata = 8'h22;
        bus.spi_wr    = 1'b1;
        tick();
        bus.spi_wr    = 1'b0;
        check("rbw_old", disp_data, 8'h11);
        tick();
        check("rbw_new", disp_data, 8'h22);

        // Shadowed control registers.
        spi_write(32'hFE00_0000, 8'h01);
        spi_write(32'hFE00_0001, 8'h12);
        spi_write(32'hFE00_0002, 8'h34);
        spi_read(32'hFE00_0000, 8'h81, "ctrl0_pending");
        check_osd("pre_vs", 1'b0, 8'h00, 8'h00);
        vs_edge();
        check_osd("post_vs", 1'b1, 8'h12, 8'h34);
        spi_read(32'hFE00_0000, 8'h01, "ctrl0_applied");
        spi_read(32'hFE00_0001, 8'h12, "ctrl1_rd");
        spi_read(32'hFE00_0002, 8'h34, "ctrl2_rd");
        spi_read(32'hFE00_0003, 8'h01, "frame_1");

        // Write coincident with a vsync edge takes effect one frame later.
        bus.spi_addr  = 32'hFE00_0001;
        bus.spi_wdata = 8'h56;
        bus.spi_wr    = 1'b1;
        vsync         = 1'b1;
        tick();
        bus.spi_wr    = 1'b0;
        vsync         = 1'b0;
        tick();
        check_osd("coinc", 1'b1, 8'h12, 8'h34);
        spi_read(32'hFE00_0000, 8'h81, "coinc_pending");
        vs_edge();
        check_osd("coinc_next", 1'b1, 8'h56, 8'h34);
        spi_read(32'hFE00_0000, 8'h01, "coinc_cleared");

        // Frame counter wraps after 256 edges in total; it is read-only.
        for (int i = 0; i < 253; i++) vs_edge();
        spi_read(32'hFE00_0003, 8'h00, "frame_wrap");
        spi_write(32'hFE00_0003, 8'hAA);
        spi_read(32'hFE00_0003, 8'h00, "frame_ro");
        spi_read(32'hFE00_0000, hide ? 8'h00 : 8'h01, "frame_ro_pending");
        check("wrap_en", {7'b0, osd_en}, {7'b0, !hide});

        // Autohide: four idle edges hide the OSD; a write restarts the count.
        spi_write(32'hFE00_0000, 8'h01);
        vs_edge();
        check("ah_en1", {7'b0, osd_en}, 8'h01);
        vs_edge();
        vs_edge();
        check("ah_en3", {7'b0, osd_en}, 8'h01);
        vs_edge();
        check("ah_en4", {7'b0, osd_en}, {7'b0, !hide});
        spi_read(32'hFE00_0000, hide ? 8'h00 : 8'h01, "ah_ctrl0");
        spi_write(32'hFE00_0000, 8'h01);
        vs_edge();
        vs_edge();
        vs_edge();
        spi_write(32'hFD00_0050, 8'h3C);
        vs_edge();
        check("ah_kept", {7'b0, osd_en}, 8'h01);

        // Write events during reset are dropped; a held spi_wr rewrites after it.
        spi_write(32'hFD00_0041, 8'h44);
        bus.spi_addr  = 32'hFD00_0041;
        bus.spi_wdata = 8'h99;
        bus.spi_wr    = 1'b1;
        rst           = 1'b1;
        tick();
        tick();
        check("rst2_rdata", bus.spi_rdata, 8'h00);
        check_osd("rst2_osd", 1'b0, 8'h00, 8'h00);
        bus.spi_addr  = 32'hFD00_0042;
        bus.spi_wdata = 8'h55;
        rst           = 1'b0;
        tick();
        bus.spi_wr    = 1'b0;
        tick();
        spi_read(32'hFD00_0041, 8'h44, "rst_discard");
        spi_read(32'hFD00_0042, 8'h55, "rst_rewrite");
        spi_read(32'hFE00_0000, 8'h00, "rst_ctrl0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/osd_spi_ram_ctrl.md
Name: osd_spi_ram_ctrl

Overview:
- Downstream consumer of the SPI RAM/BTN slave's BRAM interface (rd, wr, addr, data_out). Returns read data to the slave's data_in.
- Decodes two address regions: OSD character/attribute RAM and OSD control registers.
- Control registers are shadowed and move to the active set on vsync, so OSD changes are tear-free.
- Provides a read-only display port for the OSD video pipeline.

Parameters:
- c_addr_osd, 8'hFD, high address byte selecting OSD RAM
- c_addr_ctrl, 8'hFE, high address byte selecting control registers
- c_ram_bits, 11, OSD RAM address width (2^c_ram_bits bytes)
- c_addr_bits, 32, SPI address width; fixed at 32
- c_autohide_frames, 250, frame count for autohide; used only with OSD_AUTOHIDE_EN

Ports:
- clk  in  1  system clock, faster than SPI sclk
- rst  in  1  synchronous reset, active-high
- spi_rd  in  1  read strobe from SPI slave, level
- spi_wr  in  1  write strobe from SPI slave, level; one assertion per byte
- spi_addr  in  c_addr_bits  byte address from SPI slave; auto-increments per byte
- spi_wdata  in  8  write data from SPI slave
- spi_rdata  out  8  read data back to SPI slave data_in
- vsync  in  1  video vertical sync, synchronous to clk
- disp_addr  in  c_ram_bits  display-side RAM address
- disp_data  out  8  display-side RAM data
- osd_en  out  1  active OSD enable
- osd_x  out  8  active OSD X position, 8-pixel units
- osd_y  out  8  active OSD Y position, 8-pixel units

Behaviour:
- Region decode uses spi_addr[31:24]:
  - == c_addr_osd: RAM, indexed by spi_addr[c_ram_bits-1:0]; higher bits ignored, so addresses alias/wrap.
  - == c_addr_ctrl: registers, indexed by spi_addr[1:0].
  - Anything else: writes ignored, reads return 8'h00.
- Write detect: register spi_wr into wr_q. A write event is spi_wr=1 && wr_q=0, sampled with that cycle's spi_addr and spi_wdata. Exactly one RAM/register write per wr assertion, however long the assertion lasts.
- Read path: spi_rdata is registered every cycle from the currently decoded address, regardless of spi_rd, giving 1-cycle latency. The slave's dummy byte covers this latency.
- Control registers:
  - Offset 0, read/write: bit0 = shadow_en. Reads return {pending, 6'b0, shadow_en}.
  - Offset 1, read/write: shadow_x.
  - Offset 2, read/write: shadow_y.
  - Offset 3, read-only: frame_cnt. Writes are ignored and do not set pending.
- Any write to offsets 0-2 sets pending=1.
- vsync edge: register vsync into vs_q; an edge is vsync=1 && vs_q=0. On an edge:
  - {osd_en, osd_x, osd_y} <= shadow values.
  - pending <= 0.
  - frame_cnt <= frame_cnt+1, wrapping 255->0.
- Write and vsync edge in the same cycle: the active set loads the pre-write shadow values, the write lands in shadow, and pending stays 1. The new value therefore takes effect on the next edge.
- Display port: disp_data <= ram[disp_addr] every cycle (1-cycle latency), true dual-port.
- SPI write and display read to the same address in the same cycle: disp_data returns the old byte (read-before-write). The new byte is visible on the next read.
- Reset values:
  - spi_rdata=0, disp_data=0, osd_en=0, osd_x=0, osd_y=0.
  - All shadow registers 0, pending=0, frame_cnt=0, wr_q=0, vs_q=0.
  - RAM contents are not reset.
- Reset mid-transfer: any write event in a reset cycle is discarded. After reset deasserts, wr_q=0, so a still-high spi_wr counts as a new write event.

Optional Feature:
- Macro OSD_AUTOHIDE_EN.
- Defined:
  - Idle counter (8 bits minimum, saturating) increments on each vsync edge and clears on any write event in any region.
  - When the counter reaches c_autohide_frames, shadow_en and osd_en both clear in that cycle and pending is unaffected. The counter then holds until the next write.
  - A write event and a vsync edge in the same cycle clear the counter.
- Undefined: no idle counter; osd_en changes only through the shadow/vsync path.

Test Plan:
- Reset, then write 8'hA5 to 0xFD000010 and read it back: spi_rdata=8'hA5 one cycle after the address is applied. disp_addr=16'h10 gives disp_data=8'hA5 one cycle later.
- Hold spi_wr high for 10 cycles on 0xFD000020 while the slave increments the address: exactly one RAM write occurs; 0x21 is unchanged.
- Write ctrl offsets 0/1/2 = 1/8'h12/8'h34: offset 0 reads 8'h81 and osd_en stays 0 until a vsync edge. After the edge, osd_en=1, osd_x=8'h12, osd_y=8'h34, and offset 0 reads 8'h01.
- Write to offset 1 coincident with a vsync edge: osd_x keeps its old value, pending=1, and the next edge applies the new value.
- Apply 256 vsync edges: frame_cnt (offset 3) reads 0. Writing offset 3 leaves pending=0.
- With OSD_AUTOHIDE_EN and c_autohide_frames=4, enable the OSD, then apply 4 vsync edges with no writes: osd_en=0 and offset 0 reads 8'h00. Repeat with a write after edge 3: osd_en stays 1.
